// File: rtl/intt_twiddle_addr_gen_pkg.sv
// intt_twiddle_addr_gen_pkg: shared ring/PE geometry defines, FSM state type and inverse-twiddle address math
`ifndef RING_DEPTH
`define RING_DEPTH 4
`endif
`ifndef PE_DEPTH
`define PE_DEPTH 1
`endif
`ifndef TW_MEM_DEPTH
`define TW_MEM_DEPTH(rd, pd) ((pd) + (1 << ((rd) - (pd))) - 1)
`endif

package intt_twiddle_addr_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam int TW_DEPTH_DEF = `TW_MEM_DEPTH(`RING_DEPTH, `PE_DEPTH);
  // First word of stage s: one word per early stage, then 2^(s-pd) words per later stage.
  function automatic int unsigned tw_base(input int unsigned s, input int unsigned pd);
    return s < pd ? s : pd + (32'd1 << (s - pd)) - 32'd1;
  endfunction
  // Word used by butterfly j of stage s; later stages share a word across 2^(rd-1-s) butterflies.
  function automatic int unsigned tw_addr(input int unsigned s, input int unsigned j,
                                          input int unsigned rd, input int unsigned pd);
    return s < pd ? s : tw_base(s, pd) + (j >> (rd - 32'd1 - s));
  endfunction
endpackage

// File: rtl/intt_twiddle_addr_gen.sv
// intt_twiddle_addr_gen: per-PE inverse-twiddle read-address sequencer with stall and one-cycle drain
module intt_twiddle_addr_gen
  import intt_twiddle_addr_gen_pkg::*;
#(
  parameter int RING_DEPTH = `RING_DEPTH,
  parameter int PE_DEPTH   = `PE_DEPTH,
  parameter int HLEN       = 9
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               stall,
  output logic [HLEN-1:0]                    raddr,
  output logic                               addr_valid,
  output logic                               tw_valid,
  output logic [$clog2(RING_DEPTH+1)-1:0]    stage,
  output logic                               busy,
  output logic                               done
);
  localparam int JW = (RING_DEPTH - PE_DEPTH > 1) ? RING_DEPTH - PE_DEPTH - 1 : 1;
  localparam int SW = $clog2(RING_DEPTH + 1);
  localparam logic [JW-1:0] J_LAST = JW'((1 << (RING_DEPTH - PE_DEPTH - 1)) - 1);
  localparam logic [SW-1:0] S_LAST = SW'(RING_DEPTH - 1);

  state_e          state_q;
  logic [SW-1:0]   s_q, s_d;
  logic [JW-1:0]   j_q, j_d;
  logic [HLEN-1:0] raddr_q, raddr_d;
  logic            tw_valid_q;
  logic            last_j;

  assign raddr      = raddr_q;
  assign stage      = s_q;
  assign tw_valid   = tw_valid_q;
  assign addr_valid = (state_q == RUN) && !stall;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = state_q == DONE;

  // Next butterfly/stage position and the address it will need once the current one is issued.
  always_comb begin
    last_j  = j_q == J_LAST;
    j_d     = last_j ? '0 : j_q + 1'b1;
    s_d     = last_j ? s_q + 1'b1 : s_q;
    raddr_d = HLEN'(tw_addr(32'(s_d), 32'(j_d), RING_DEPTH, PE_DEPTH));
  end

  // Sequencer: raddr_q always holds the pending address, advancing only when it is issued unstalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      s_q        <= '0;
      j_q        <= '0;
      raddr_q    <= '0;
      tw_valid_q <= 1'b0;
    end else begin
      tw_valid_q <= addr_valid;
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          s_q     <= '0;
          j_q     <= '0;
          raddr_q <= '0;
        end
        RUN: if (!stall) begin
          if (last_j && s_q == S_LAST) state_q <= DRAIN;
          else begin
            s_q     <= s_d;
            j_q     <= j_d;
            raddr_q <= raddr_d;
          end
        end
        DRAIN:   state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_intt_twiddle_addr_gen.sv
// tb_intt_twiddle_addr_gen: directed checks of address order, stall, restart, reset and a 10/5 geometry
module tb_intt_twiddle_addr_gen;
  logic       clk = 1'b0;
  logic       reset, start, stall, start10;
  logic [8:0] raddr, raddr10;
  logic       av, tv, busy, done, av10, tv10, busy10, done10;
  logic [2:0] stage;
  logic [3:0] stage10;
  logic [7:0] mem_dout;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         max_addr = 0;
  int         exp_tbl [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= 8'(raddr) ^ 8'h5A;

  intt_twiddle_addr_gen #(.RING_DEPTH(4), .PE_DEPTH(1), .HLEN(9)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .raddr(raddr),
    .addr_valid(av), .tw_valid(tv), .stage(stage), .busy(busy), .done(done));

  intt_twiddle_addr_gen #(.RING_DEPTH(10), .PE_DEPTH(5), .HLEN(9)) dut10 (
    .clk(clk), .reset(reset), .start(start10), .stall(1'b0), .raddr(raddr10),
    .addr_valid(av10), .tw_valid(tv10), .stage(stage10), .busy(busy10), .done(done10));

  task automatic run_seq(input string name, input int st_from, input int st_to,
                         input int restart_at, input int exp_done);
    int         k = 0;
    logic       prev_av = 1'b0;
    logic       exp_av;
    logic [8:0] prev_addr = '0;
    @(posedge clk); #1;
    start = 1'b1;
    stall = (st_from <= 0) && (st_to >= 0);
    #1;
    n_cmp++;
    if (av !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s c0 idle: addr_valid=%b busy=%b required 0 0", name, av, busy);
    end
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(posedge clk); #1;
      start = (c == restart_at);
      stall = (c >= st_from) && (c <= st_to);
      #1;
      exp_av = (k < 16) && !stall;
      n_cmp++;
      if (tv !== prev_av) begin
        n_bad++;
        $display("FAIL %s c%0d tw_valid: got %b required %b", name, c, tv, prev_av);
      end
      if (prev_av) begin
        n_cmp++;
        if (mem_dout !== (8'(prev_addr) ^ 8'h5A)) begin
          n_bad++;
          $display("FAIL %s c%0d mem word: got %h required %h", name, c, mem_dout, 8'(prev_addr) ^ 8'h5A);
        end
      end
      n_cmp++;
      if (av !== exp_av) begin
        n_bad++;
        $display("FAIL %s c%0d addr_valid: got %b required %b", name, c, av, exp_av);
      end
      if (av === 1'b1 && int'(raddr) > max_addr) max_addr = int'(raddr);
      if (exp_av) begin
        n_cmp++;
        if (raddr !== 9'(exp_tbl[k]) || stage !== 3'(k / 4)) begin
          n_bad++;
          $display("FAIL %s c%0d raddr/stage: got %0d/%0d required %0d/%0d", name, c, raddr, stage, exp_tbl[k], k / 4);
        end
        prev_addr = 9'(exp_tbl[k]);
        k++;
      end
      n_cmp++;
      if (busy !== (c < exp_done) || done !== (c == exp_done)) begin
        n_bad++;
        $display("FAIL %s c%0d busy/done: got %b/%b required %b/%b", name, c, busy, done, c < exp_done, c == exp_done);
      end
      prev_av = exp_av;
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0; start10 = 1'b0;
    #12;
    n_cmp++;
    if ({raddr, av, tv, stage, busy, done} !== '0 || {raddr10, av10, tv10, stage10, busy10, done10} !== '0) begin
      n_bad++;
      $display("FAIL reset state: got %0d %b %b %0d %b %b required all zero", raddr, av, tv, stage, busy, done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #2;
    n_cmp++;
    if (av !== 1'b1 || raddr !== 9'd2 || stage !== 3'd2) begin
      n_bad++;
      $display("FAIL mid_run c10 before reset: got av=%b raddr=%0d stage=%0d required 1 2 2", av, raddr, stage);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({raddr, av, tv, stage, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL async reset: got %0d %b %b %0d %b %b required all zero", raddr, av, tv, stage, busy, done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b0 || av !== 1'b0) begin
      n_bad++;
      $display("FAIL after reset wait: got busy=%b av=%b required 0 0", busy, av);
    end
    run_seq("after_reset", -1, -1, -1, 18);
  endtask

  task automatic test_mem_model();
    max_addr = 0;
    run_seq("mem_model", -1, -1, -1, 18);
    n_cmp++;
    if (max_addr !== 7) begin
      n_bad++;
      $display("FAIL max address: got %0d required 7", max_addr);
    end
  endtask

  task automatic test_ring10();
    int cnt = 0;
    int mx = 0;
    int done_c = -1;
    @(posedge clk); #1;
    start10 = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      start10 = 1'b0;
      #1;
      if (av10 === 1'b1) begin
        if (cnt == 79 || cnt == 80 || cnt == 159) begin
          n_cmp++;
          if (raddr10 !== (cnt == 79 ? 9'd4 : cnt == 80 ? 9'd5 : 9'd35) ||
              stage10 !== (cnt == 79 ? 4'd4 : cnt == 80 ? 4'd5 : 4'd9)) begin
            n_bad++;
            $display("FAIL ring10 idx%0d: got raddr=%0d stage=%0d", cnt, raddr10, stage10);
          end
        end
        if (int'(raddr10) > mx) mx = int'(raddr10);
        cnt++;
      end
      if (done10 === 1'b1) begin
        done_c = c;
        break;
      end
    end
    n_cmp++;
    if (cnt != 160) begin
      n_bad++;
      $display("FAIL ring10 count: got %0d required 160", cnt);
    end
    n_cmp++;
    if (mx != 35) begin
      n_bad++;
      $display("FAIL ring10 max address: got %0d required 35", mx);
    end
    n_cmp++;
    if (done_c != 162) begin
      n_bad++;
      $display("FAIL ring10 done cycle: got %0d required 162 (-1 means timeout)", done_c);
    end
  endtask

  initial begin
    test_reset();
    run_seq("basic", -1, -1, -1, 18);
    run_seq("stall_5_7", 5, 7, -1, 21);
    run_seq("restart_run", -1, -1, 8, 18);
    run_seq("restart_done", -1, -1, 18, 18);
    run_seq("stall_idle", 0, 0, -1, 18);
    run_seq("stall_drain", 17, 18, -1, 18);
    run_seq("stall_first", 1, 2, -1, 20);
    test_reset_mid();
    test_mem_model();
    test_ring10();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
